// File: rtl/calc_seq_pkg.sv
// Shared types and memory map for the calculator run sequencer.
// The sequencer's optional feature is selected with SEQ_PERF_CNT_EN.
package calc_seq_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LAUNCH = 3'd1,
    RUN    = 3'd2,
    DONE   = 3'd3,
    FAULT  = 3'd4
  } seq_state_t;

  // Operand mailbox written by the front-end before a run.
  localparam logic [31:0] OP1_ADDR      = 32'd220;
  localparam logic [31:0] OP2_ADDR      = 32'd224;
  localparam logic [31:0] OPCODE_ADDR   = 32'd228;
  // A CPU store here carries the result and marks the run complete.
  localparam logic [31:0] DONE_ADDR_DEF = 32'd320;

endpackage

// File: rtl/run_watchdog.sv
// Saturating run-cycle counter with a watchdog flag on the last budgeted cycle.
module run_watchdog #(
  parameter int MAX_CYCLES = 200
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              clr,
  input  logic                              en,
  output logic [$clog2(MAX_CYCLES+1)-1:0]   count,
  output logic                              expired
);

  localparam int CW = $clog2(MAX_CYCLES + 1);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && (count_q != CW'(MAX_CYCLES))) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count   = count_q;
  // Budget is spent once the current cycle is the last allowed one.
  assign expired = en && (count_q == CW'(MAX_CYCLES - 1));

endmodule

// File: rtl/calc_run_sequencer.sv
// Memory arbiter, CPU launcher/watchdog and result latch for the calculator.
// Optional: define SEQ_PERF_CNT_EN to add the run_cycles output.
module calc_run_sequencer
  import calc_seq_pkg::*;
#(
  parameter int                ADDR_W     = 32,
  parameter int                DATA_W     = 32,
  parameter int                MAX_CYCLES = 200,
  parameter logic [ADDR_W-1:0] DONE_ADDR  = ADDR_W'(DONE_ADDR_DEF)
) (
  input  logic                            hz100,
  input  logic                            reset,
  input  logic                            fe_start,
  input  logic                            fe_clear,
  input  logic                            fe_wen,
  input  logic                            fe_ren,
  input  logic [ADDR_W-1:0]               fe_addr,
  input  logic [DATA_W-1:0]               fe_wdata,
  output logic                            fe_busy,
  input  logic                            cpu_wen,
  input  logic                            cpu_ren,
  input  logic [ADDR_W-1:0]               cpu_addr,
  input  logic [DATA_W-1:0]               cpu_wdata,
  output logic                            cpu_en,
  output logic                            cpu_rst,
  output logic                            mem_wen,
  output logic                            mem_ren,
  output logic [ADDR_W-1:0]               mem_addr,
  output logic [DATA_W-1:0]               mem_wdata,
  input  logic [DATA_W-1:0]               mem_rdata,
  output logic [DATA_W-1:0]               rd_data,
  output logic [DATA_W-1:0]               result,
  output logic                            result_vld,
  output logic                            fault,
`ifdef SEQ_PERF_CNT_EN
  output logic [$clog2(MAX_CYCLES+1)-1:0] run_cycles,
`endif
  output logic [$clog2(MAX_CYCLES+1)-1:0] dbg_count,
  output seq_state_t                      dbg_state
);

  localparam int CW = $clog2(MAX_CYCLES + 1);

  seq_state_t    state_q, state_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic          wd_clr;
  logic          wd_expired;
  logic [CW-1:0] wd_count;
  logic          done_store;
`ifdef SEQ_PERF_CNT_EN
  logic [CW-1:0] run_cycles_q, run_cycles_d;
`endif

  run_watchdog #(.MAX_CYCLES(MAX_CYCLES)) u_watchdog (
    .clk     (hz100),
    .rst     (reset),
    .clr     (wd_clr),
    .en      (state_q == RUN),
    .count   (wd_count),
    .expired (wd_expired)
  );

  assign done_store = (state_q == RUN) && cpu_wen && (cpu_addr == DONE_ADDR);

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    wd_clr   = 1'b0;
`ifdef SEQ_PERF_CNT_EN
    run_cycles_d = run_cycles_q;
`endif
    if (fe_clear) begin
      state_d = IDLE;
      wd_clr  = 1'b1;
`ifdef SEQ_PERF_CNT_EN
      run_cycles_d = '0;
`endif
    end else begin
      case (state_q)
        IDLE, DONE, FAULT: begin
          if (fe_start) begin
            state_d = LAUNCH;
            wd_clr  = 1'b1;
          end
        end
        LAUNCH: state_d = RUN;
        RUN: begin
          // The done-store wins over an expiring budget on the same cycle.
          if (done_store) begin
            state_d  = DONE;
            result_d = cpu_wdata;
`ifdef SEQ_PERF_CNT_EN
            run_cycles_d = wd_count + CW'(1);
`endif
          end else if (wd_expired) begin
            state_d = FAULT;
`ifdef SEQ_PERF_CNT_EN
            run_cycles_d = wd_count + CW'(1);
`endif
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge hz100 or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      result_q <= '0;
`ifdef SEQ_PERF_CNT_EN
      run_cycles_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
`ifdef SEQ_PERF_CNT_EN
      run_cycles_q <= run_cycles_d;
`endif
    end
  end

  // Request semantics: a side's wen/ren is honoured only in the cycle it owns
  // the port; the losing side's request is dropped, and fe_busy reports that.
  always_comb begin
    if (state_q == RUN) begin
      mem_wen   = cpu_wen;
      mem_ren   = cpu_ren;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
      fe_busy   = fe_wen | fe_ren;
    end else begin
      mem_wen   = fe_wen;
      mem_ren   = fe_ren;
      mem_addr  = fe_addr;
      mem_wdata = fe_wdata;
      fe_busy   = 1'b0;
    end
  end

  assign rd_data    = mem_rdata;
  assign cpu_en     = (state_q == RUN);
  assign cpu_rst    = (state_q == LAUNCH);
  assign result     = result_q;
  assign result_vld = (state_q == DONE);
  assign fault      = (state_q == FAULT);
  assign dbg_state  = state_q;
  assign dbg_count  = wd_count;
`ifdef SEQ_PERF_CNT_EN
  assign run_cycles = run_cycles_q;
`endif

endmodule

// File: tb/tb_calc_run_sequencer.sv
// Directed bench for calc_run_sequencer: vector table for the memory mux plus
// hand-written sequences for runs, watchdog, clear and reset.
module tb_calc_run_sequencer;
  import calc_seq_pkg::*;

  localparam int CW = 8;

  logic        hz100, reset;
  logic        fe_start, fe_clear, fe_wen, fe_ren;
  logic [31:0] fe_addr, fe_wdata;
  logic        fe_busy;
  logic        cpu_wen, cpu_ren;
  logic [31:0] cpu_addr, cpu_wdata;
  logic        cpu_en, cpu_rst;
  logic        mem_wen, mem_ren;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, rd_data;
  logic [31:0] result;
  logic        result_vld, fault;
  logic [CW-1:0] dbg_count;
  seq_state_t  dbg_state;
`ifdef SEQ_PERF_CNT_EN
  logic [CW-1:0] run_cycles;
`endif

  calc_run_sequencer dut (
    .hz100(hz100), .reset(reset),
    .fe_start(fe_start), .fe_clear(fe_clear), .fe_wen(fe_wen), .fe_ren(fe_ren),
    .fe_addr(fe_addr), .fe_wdata(fe_wdata), .fe_busy(fe_busy),
    .cpu_wen(cpu_wen), .cpu_ren(cpu_ren), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_en(cpu_en), .cpu_rst(cpu_rst),
    .mem_wen(mem_wen), .mem_ren(mem_ren), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .rd_data(rd_data),
    .result(result), .result_vld(result_vld), .fault(fault),
`ifdef SEQ_PERF_CNT_EN
    .run_cycles(run_cycles),
`endif
    .dbg_count(dbg_count), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial hz100 = 1'b0;
  always #5 hz100 = ~hz100;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish (got running, expected done)");
    $fatal(1);
  end

  // ---------------- memory model ----------------
  logic [31:0] mem [0:127];
  logic        mem_clr;
  always @(posedge hz100) begin
    if (mem_clr) begin
      for (int k = 0; k < 128; k++) mem[k] <= 32'd0;
    end else if (mem_wen) begin
      mem[mem_addr[8:2]] <= mem_wdata;
    end
  end
  assign mem_rdata = mem[mem_addr[8:2]];

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge hz100);
    #1;
  endtask

  task automatic idle_inputs();
    fe_start = 0; fe_clear = 0; fe_wen = 0; fe_ren = 0; fe_addr = 0; fe_wdata = 0;
    cpu_wen = 0; cpu_ren = 0; cpu_addr = 0; cpu_wdata = 0;
  endtask

  task automatic fe_write(input logic [31:0] a, input logic [31:0] d);
    fe_wen = 1; fe_addr = a; fe_wdata = d;
    tick();
    idle_inputs();
  endtask

  task automatic pulse_start();
    fe_start = 1;
    tick();
    fe_start = 0;
  endtask

  task automatic done_store(input logic [31:0] d);
    cpu_wen = 1; cpu_addr = 32'd320; cpu_wdata = d;
    tick();
    idle_inputs();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        run;
    logic        fe_wen, fe_ren;
    logic [31:0] fe_addr, fe_wdata;
    logic        cpu_wen, cpu_ren;
    logic [31:0] cpu_addr, cpu_wdata;
    logic        e_wen, e_ren, e_busy;
    logic [31:0] e_addr, e_wdata;
  } vec_t;

  vec_t vecs [7];

  task automatic apply_vec(input int i);
    fe_wen = vecs[i].fe_wen; fe_ren = vecs[i].fe_ren;
    fe_addr = vecs[i].fe_addr; fe_wdata = vecs[i].fe_wdata;
    cpu_wen = vecs[i].cpu_wen; cpu_ren = vecs[i].cpu_ren;
    cpu_addr = vecs[i].cpu_addr; cpu_wdata = vecs[i].cpu_wdata;
    #1;
    check($sformatf("vec%0d mem_wen", i), 32'(mem_wen), 32'(vecs[i].e_wen));
    check($sformatf("vec%0d mem_ren", i), 32'(mem_ren), 32'(vecs[i].e_ren));
    check($sformatf("vec%0d fe_busy", i), 32'(fe_busy), 32'(vecs[i].e_busy));
    check($sformatf("vec%0d mem_addr", i), mem_addr, vecs[i].e_addr);
    check($sformatf("vec%0d mem_wdata", i), mem_wdata, vecs[i].e_wdata);
    tick();
    idle_inputs();
  endtask

  // ---------------- test ----------------
  initial begin
    int cnt;
    //         run fw fr fe_addr fe_wd cw cr cpu_a cpu_wd   ew er eb e_addr e_wd
    vecs[0] = '{1'b0, 1'b1, 1'b0, 32'd64, 32'd170, 1'b1, 1'b0, 32'd128, 32'd85,
                1'b1, 1'b0, 1'b0, 32'd64, 32'd170};
    vecs[1] = '{1'b0, 1'b0, 1'b1, 32'd64, 32'd0, 1'b0, 1'b1, 32'd132, 32'd0,
                1'b0, 1'b1, 1'b0, 32'd64, 32'd0};
    vecs[2] = '{1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 32'd320, 32'd7,
                1'b0, 1'b0, 1'b0, 32'd0, 32'd0};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 32'd68, 32'd153, 1'b0, 1'b1, 32'd136, 32'd0,
                1'b0, 1'b1, 1'b1, 32'd136, 32'd0};
    vecs[4] = '{1'b1, 1'b0, 1'b1, 32'd64, 32'd0, 1'b0, 1'b0, 32'd140, 32'd0,
                1'b0, 1'b0, 1'b1, 32'd140, 32'd0};
    vecs[5] = '{1'b1, 1'b1, 1'b0, 32'd72, 32'd51, 1'b1, 1'b0, 32'd144, 32'd4660,
                1'b1, 1'b0, 1'b1, 32'd144, 32'd4660};
    vecs[6] = '{1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 32'd148, 32'd0,
                1'b0, 1'b1, 1'b0, 32'd148, 32'd0};

    idle_inputs();
    reset = 1; mem_clr = 1;
    tick(); tick();
    check("rst state", 32'(dbg_state), 32'(IDLE));
    check("rst cpu_en", 32'(cpu_en), 0);
    check("rst cpu_rst", 32'(cpu_rst), 0);
    check("rst result", result, 0);
    check("rst result_vld", 32'(result_vld), 0);
    check("rst fault", 32'(fault), 0);
    check("rst count", 32'(dbg_count), 0);
    reset = 0; mem_clr = 0;
    tick();

    // Normal run
    fe_write(32'd220, 32'd12);
    fe_write(32'd224, 32'd34);
    fe_write(32'd228, 32'd8);
    fe_ren = 1; fe_addr = 32'd224; #1;
    check("readback rd_data", rd_data, 32'd34);
    fe_ren = 0;
    pulse_start();
    check("launch state", 32'(dbg_state), 32'(LAUNCH));
    check("launch cpu_rst", 32'(cpu_rst), 1);
    check("launch cpu_en", 32'(cpu_en), 0);
    tick();
    check("run1 cpu_rst", 32'(cpu_rst), 0);
    check("run1 cpu_en", 32'(cpu_en), 1);
    repeat (39) tick();
    check("run40 state", 32'(dbg_state), 32'(RUN));
    check("run40 count", 32'(dbg_count), 32'd39);
    cpu_wen = 1; cpu_addr = 32'd320; cpu_wdata = 32'd408; #1;
    check("store mem_wen", 32'(mem_wen), 1);
    check("store mem_addr", mem_addr, 32'd320);
    tick();
    idle_inputs();
    check("done state", 32'(dbg_state), 32'(DONE));
    check("done result", result, 32'd408);
    check("done result_vld", 32'(result_vld), 1);
    check("done cpu_en", 32'(cpu_en), 0);
    check("done mem word", mem[80], 32'd408);
`ifdef SEQ_PERF_CNT_EN
    check("done run_cycles", 32'(run_cycles), 32'd40);
`endif

    // Arbitration outside RUN (in DONE)
    for (int i = 0; i < 7; i++) if (!vecs[i].run) apply_vec(i);
    check("done kept state", 32'(dbg_state), 32'(DONE));
    check("done kept result", result, 32'd408);
    check("fe write landed", mem[16], 32'd170);

    // Re-run from DONE, fe_start mid-run ignored, then watchdog
    pulse_start();
    check("rerun result_vld", 32'(result_vld), 0);
    check("rerun state", 32'(dbg_state), 32'(LAUNCH));
    cnt = 0;
    for (int i = 0; i < 300; i++) begin
      if (cnt == 5) fe_start = 1;
      tick();
      fe_start = 0;
      if (cpu_en) cnt++;
      else if (cnt > 0) break;
    end
    check("wd cpu_en cycles", cnt, 32'd200);
    check("wd state", 32'(dbg_state), 32'(FAULT));
    check("wd fault", 32'(fault), 1);
    check("wd result_vld", 32'(result_vld), 0);
    check("wd result kept", result, 32'd408);
    check("wd count", 32'(dbg_count), 32'd200);
`ifdef SEQ_PERF_CNT_EN
    check("wd run_cycles", 32'(run_cycles), 32'd200);
`endif

    // Arbitration during RUN
    pulse_start();
    tick();
    for (int i = 0; i < 7; i++) if (vecs[i].run) apply_vec(i);
    check("blocked fe write 68", mem[17], 32'd0);
    check("blocked fe write 72", mem[18], 32'd0);
    check("cpu write 144", mem[36], 32'd4660);

    // Done-store and fe_clear on one edge
    check("pre-clear state", 32'(dbg_state), 32'(RUN));
    cpu_wen = 1; cpu_addr = 32'd320; cpu_wdata = 32'd999; fe_clear = 1;
    tick();
    idle_inputs();
    check("clr state", 32'(dbg_state), 32'(IDLE));
    check("clr result_vld", 32'(result_vld), 0);
    check("clr fault", 32'(fault), 0);
    check("clr cpu_en", 32'(cpu_en), 0);

    // Done-store on the watchdog's last cycle
    pulse_start();
    tick();
    repeat (199) tick();
    check("last cycle state", 32'(dbg_state), 32'(RUN));
    done_store(32'd555);
    check("last done state", 32'(dbg_state), 32'(DONE));
    check("last fault", 32'(fault), 0);
    check("last result", result, 32'd555);
    check("last result_vld", 32'(result_vld), 1);
`ifdef SEQ_PERF_CNT_EN
    check("last run_cycles", 32'(run_cycles), 32'd200);
`endif

    // Reset mid-RUN, asserted between edges
    pulse_start();
    tick();
    repeat (4) tick();
    check("run5 cpu_en", 32'(cpu_en), 1);
    #2 reset = 1;
    #1;
    check("async rst state", 32'(dbg_state), 32'(IDLE));
    check("async rst cpu_en", 32'(cpu_en), 0);
    check("async rst result_vld", 32'(result_vld), 0);
    check("async rst result", result, 0);
    check("async rst mem kept", mem[80], 32'd555);
    tick();
    reset = 0;
    tick();
    check("post rst state", 32'(dbg_state), 32'(IDLE));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
